exp2_rsa_core: RTL and testbench
================================

// Module: exp2_rsa_core
// PURPOSE
// - 256-bit RSA modular-exponentiation engine: computes M = C^E mod N.
// - Host loads N, E and C one byte at a time through a byte-addressed register file.
// - Host pulses start, waits for ready to rise, then reads M back byte by byte.
// - Also drives buffered copies of its host-side inputs for logic-analyzer probing.
// PARAMETERS
// - none; operand width fixed at 256 bits (32 bytes, 5-bit byte address).
// PORTS
// - clk        in   1  system clock; all state updates on rising edge.
// - reset      in   1  synchronous, active-high reset.
// - ready      out  1  high = result valid / idle; low while computing.
// - we         in   1  byte write enable.
// - oe         in   1  output enable for reading the result register.
// - start      in   1  one-cycle pulse that launches an exponentiation.
// - reg_sel    in   2  register select: 3=N (modulus), 2=E (exponent), 1=C (input), 0=M (result, read-only).
// - addr       in   5  byte index; byte k = bits [8k+7:8k] (byte 0 = LSB).
// - data_i     in   8  write data.
// - data_o     out  8  read data.
// - clk_o, reset_o, ready_o, we_o, oe_o, start_o  out 1 each    combinational copies of same-named signal.
// - reg_sel_o  out  2  copy of reg_sel.
// - addr_o     out  5  copy of addr.
// - data_i_o   out  8  copy of data_i.
// BEHAVIOUR
// - Reset: N, E, C and M all cleared to 0; ready=0; FSM in IDLE; any running job aborted.
// - Write: on a clk edge with we=1 and reg_sel in {1,2,3}, reg[reg_sel][8*addr+:8] <= data_i.
//   Writes with reg_sel=0 are ignored. Back-to-back writes are allowed, one byte per cycle.
// - Read: data_o = oe ? M[8*addr+:8] : 8'h00 (combinational). Value is valid within the same cycle addr changes.
// - FSM states:
//   IDLE: start=1 -> LOAD.
//   LOAD: snapshot N, E and C into working registers; clear ready; -> EXP.
//   EXP: right-to-left square-and-multiply over E bits 0..255.
//   DONE: write the result to M, set ready=1; -> IDLE.
// - ready stays high until the next accepted start; it falls in the cycle after start is sampled.
// - start while busy (LOAD or EXP) is ignored. Writes to N, E or C while busy update those registers but do not affect the running job.
// - Modular multiply: interleaved shift-add, one multiplier bit per cycle.
//   Each step: P = 2P + b_i*B, then conditionally subtract N up to twice so that P < N.
//   Use 258-bit intermediates; no overflow is permitted.
// - One EXP step runs the square (S = S*S mod N) and the conditional multiply (R = R*S mod N, only if E[i]=1) in parallel.
//   Initial values: R = 1 mod N, S = C mod N.
// - Latency: start pulse to ready rising is at most 70,000 cycles for any operands.
// - Operand rules: N >= 2; C and E are arbitrary 256-bit values.
//   E=0 -> M = 1 mod N. C >= N is reduced before use.
//   N = 0 or 1 -> M = 0 (defined, not an error).
// - M holds its value until the next job completes or reset; a job never produces partial results in M.
// TESTING
// - Reset, then read all 32 bytes with oe=1 -> all 8'h00; ready=0; start_o/addr_o mirror their inputs.
// - N=1000, E=10, C=2 (rest of bytes 0), pulse start -> ready rises; M byte0=8'h18, bytes 1..31=8'h00.
// - Textbook RSA, N=3233: E=17, C=65 -> M=2790 (bytes 0..1 = E6 0A); then E=2753, C=2790 -> M=65 (byte0 8'h41).
// - E=0, N=7, C=3 -> M=1; and C=N+5 with E=1 -> M=5 (input reduction).
// - Random 256-bit N (odd, top bit set), E and C: at least 2 jobs back-to-back, reloading only C. M must match a software pow(C,E,N).
// - Robustness: a second start pulse mid-job and C rewritten mid-job -> result still that of the original operands.
//   Assert reset mid-job -> ready=0 and M=0.

Source files
------------

// File: rtl/exp2_rsa_core.sv
// 256-bit modular exponentiation engine, M = C^E mod N.
// Right-to-left square-and-multiply with bit-serial interleaved modmul.
module exp2_rsa_core (
  input  logic       clk,
  input  logic       reset,
  output logic       ready,
  input  logic       we,
  input  logic       oe,
  input  logic       start,
  input  logic [1:0] reg_sel,
  input  logic [4:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       clk_o,
  output logic       reset_o,
  output logic       ready_o,
  output logic       we_o,
  output logic       oe_o,
  output logic       start_o,
  output logic [1:0] reg_sel_o,
  output logic [4:0] addr_o,
  output logic [7:0] data_i_o
);

  typedef enum logic [2:0] {IDLE, LOAD, RED, EXP, DONE} state_t;

  state_t       state_q, state_d;
  logic         ready_q, ready_d;
  logic [255:0] n_q, n_d, e_q, e_d, c_q, c_d, m_q, m_d;
  logic [255:0] nw_q, nw_d, ew_q, ew_d, cw_q, cw_d;
  logic [255:0] r_q, r_d, s_q, s_d, pr_q, pr_d, ps_q, ps_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [255:0] pr_nx, ps_nx;
  logic         red;

  // One shift-add step: 2P + bit*B, then at most two subtractions of N.
  function automatic logic [255:0] mstep(
    input logic [255:0] p,
    input logic         b_i,
    input logic [255:0] b,
    input logic [255:0] n
  );
    logic [257:0] t;
    logic [257:0] nn;
    nn = {2'b00, n};
    t  = {1'b0, p, 1'b0} + (b_i ? {2'b00, b} : 258'd0);
    if (t >= nn) t = t - nn;
    if (t >= nn) t = t - nn;
    return t[255:0];
  endfunction

  assign red   = (state_q == RED);
  assign pr_nx = mstep(pr_q, r_q[cnt_q], s_q, nw_q);
  assign ps_nx = mstep(ps_q, red ? cw_q[cnt_q] : s_q[cnt_q],
                       red ? 256'd1 : s_q, nw_q);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    n_d     = n_q;
    e_d     = e_q;
    c_d     = c_q;
    m_d     = m_q;
    nw_d    = nw_q;
    ew_d    = ew_q;
    cw_d    = cw_q;
    r_d     = r_q;
    s_d     = s_q;
    pr_d    = pr_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    if (we) begin
      unique case (reg_sel)
        2'd3:    n_d[{addr, 3'b000} +: 8] = data_i;
        2'd2:    e_d[{addr, 3'b000} +: 8] = data_i;
        2'd1:    c_d[{addr, 3'b000} +: 8] = data_i;
        default: ;
      endcase
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          ready_d = 1'b0;
        end
      end
      LOAD: begin
        nw_d    = n_q;
        ew_d    = e_q;
        cw_d    = c_q;
        r_d     = {255'd0, n_q >= 256'd2};
        pr_d    = '0;
        ps_d    = '0;
        cnt_d   = 8'hff;
        state_d = RED;
      end
      RED: begin
        ps_d  = ps_nx;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          s_d     = ps_nx;
          ps_d    = '0;
          state_d = (ew_q == '0) ? DONE : EXP;
        end
      end
      EXP: begin
        pr_d  = pr_nx;
        ps_d  = ps_nx;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          s_d  = ps_nx;
          if (ew_q[0]) r_d = pr_nx;
          ew_d = ew_q >> 1;
          pr_d = '0;
          ps_d = '0;
          // Stop once no set exponent bits remain.
          if (ew_q[255:1] == '0) state_d = DONE;
        end
      end
      DONE: begin
        m_d     = (nw_q < 256'd2) ? '0 : r_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      n_q     <= '0;
      e_q     <= '0;
      c_q     <= '0;
      m_q     <= '0;
      nw_q    <= '0;
      ew_q    <= '0;
      cw_q    <= '0;
      r_q     <= '0;
      s_q     <= '0;
      pr_q    <= '0;
      ps_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      n_q     <= n_d;
      e_q     <= e_d;
      c_q     <= c_d;
      m_q     <= m_d;
      nw_q    <= nw_d;
      ew_q    <= ew_d;
      cw_q    <= cw_d;
      r_q     <= r_d;
      s_q     <= s_d;
      pr_q    <= pr_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready     = ready_q;
  assign data_o    = oe ? m_q[{addr, 3'b000} +: 8] : 8'h00;
  assign clk_o     = clk;
  assign reset_o   = reset;
  assign ready_o   = ready_q;
  assign we_o      = we;
  assign oe_o      = oe;
  assign start_o   = start;
  assign reg_sel_o = reg_sel;
  assign addr_o    = addr;
  assign data_i_o  = data_i;

endmodule

// File: tb/tb_exp2_rsa_core.sv
// Directed + random bench for exp2_rsa_core.
// Expected results queue up at start and are checked when ready rises.
module tb_exp2_rsa_core;

  logic       clk = 1'b0;
  logic       reset, we, oe, start;
  logic [1:0] reg_sel;
  logic [4:0] addr;
  logic [7:0] data_i;
  logic       ready;
  logic [7:0] data_o;
  logic       clk_o, reset_o, ready_o, we_o, oe_o, start_o;
  logic [1:0] reg_sel_o;
  logic [4:0] addr_o;
  logic [7:0] data_i_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [255:0] sb[$];
  logic [255:0] rn, re, rc, got, last_m;

  exp2_rsa_core dut (
    .clk(clk), .reset(reset), .ready(ready), .we(we), .oe(oe),
    .start(start), .reg_sel(reg_sel), .addr(addr), .data_i(data_i),
    .data_o(data_o), .clk_o(clk_o), .reset_o(reset_o),
    .ready_o(ready_o), .we_o(we_o), .oe_o(oe_o), .start_o(start_o),
    .reg_sel_o(reg_sel_o), .addr_o(addr_o), .data_i_o(data_i_o)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] ref_pow(
    input logic [255:0] c, input logic [255:0] e, input logic [255:0] n);
    logic [511:0] r, s, nn;
    if (n < 256'd2) return '0;
    nn = {256'd0, n};
    r  = 512'd1;
    s  = {256'd0, c} % nn;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = (r * s) % nn;
      s = (s * s) % nn;
    end
    return r[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [255:0] v);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      we = 1'b1;
      reg_sel = sel;
      addr = k[4:0];
      data_i = v[8*k +: 8];
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_m(output logic [255:0] v);
    v = '0;
    oe = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      addr = k[4:0];
      #1;
      v[8*k +: 8] = data_o;
    end
    @(negedge clk);
    oe = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      #1;
      if (ready) break;
    end
    check({tag, "_ready"}, {255'd0, ready}, 256'd1);
  endtask

  task automatic finish_job(input string tag);
    logic [255:0] exp;
    logic [255:0] v;
    wait_ready(tag);
    exp = sb.pop_front();
    read_m(v);
    check(tag, v, exp);
    last_m = exp;
  endtask

  task automatic job(input string tag, input logic [255:0] n,
                     input logic [255:0] e, input logic [255:0] c,
                     input logic [255:0] exp);
    write_reg(2'd3, n);
    write_reg(2'd2, e);
    write_reg(2'd1, c);
    sb.push_back(exp);
    pulse_start();
    finish_job(tag);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; oe = 1'b0; start = 1'b0;
    reg_sel = 2'd0; addr = 5'd0; data_i = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; addr = 5'h13; data_i = 8'hA5; reg_sel = 2'd2;
    #1;
    check("start_o", {255'd0, start_o}, 256'd1);
    check("addr_o", {251'd0, addr_o}, 256'h13);
    check("data_i_o", {248'd0, data_i_o}, 256'hA5);
    check("reg_sel_o", {254'd0, reg_sel_o}, 256'd2);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_o_low", {255'd0, start_o}, 256'd0);
    @(negedge clk);
    reset = 1'b0;
    check("reset_ready", {255'd0, ready}, 256'd0);
    read_m(got);
    check("reset_m", got, 256'd0);

    job("pow_2_10", 256'd1000, 256'd10, 256'd2, 256'd24);
    oe = 1'b1;
    addr = 5'd0;
    #1;
    check("byte0", {248'd0, data_o}, 256'h18);
    oe = 1'b0;
    #1;
    check("oe_low", {248'd0, data_o}, 256'h00);

    job("rsa_enc", 256'd3233, 256'd17, 256'd65, 256'd2790);
    job("rsa_dec", 256'd3233, 256'd2753, 256'd2790, 256'd65);
    job("e_zero", 256'd7, 256'd0, 256'd3, 256'd1);
    job("c_reduce", 256'd7, 256'd1, 256'd12, 256'd5);
    job("n_one", 256'd1, 256'd5, 256'd3, 256'd0);

    rn = rand256();
    rn[255] = 1'b1;
    rn[0] = 1'b1;
    re = {224'd0, $urandom};
    rc = rand256();
    job("rand0", rn, re, rc, ref_pow(rc, re, rn));
    rc = rand256();
    write_reg(2'd1, rc);
    sb.push_back(ref_pow(rc, re, rn));
    pulse_start();
    finish_job("rand1");

    write_reg(2'd3, 256'd3233);
    write_reg(2'd2, 256'd2753);
    write_reg(2'd1, 256'd2790);
    sb.push_back(256'd65);
    pulse_start();
    repeat (300) @(posedge clk);
    pulse_start();
    write_reg(2'd1, 256'd5);
    #1;
    check("busy_ready", {255'd0, ready}, 256'd0);
    read_m(got);
    check("m_hold", got, last_m);
    finish_job("robust");

    write_reg(2'd1, 256'd2790);
    pulse_start();
    repeat (200) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ready", {255'd0, ready}, 256'd0);
    @(negedge clk);
    reset = 1'b0;
    read_m(got);
    check("rst_mid_m", got, 256'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
